// File: rtl/gf233_karatsuba_seq.sv
// gf233_karatsuba_seq: unreduced 233x233 GF(2)[x] multiply, one level of
// Karatsuba over a shared external 117x117 multiplier (three issues per op).
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    operand handshake, a and b (233 bits)
//   out_valid/out_ready  result handshake, d (465 bits, unreduced product)
//   mul_valid/mul_a/mul_b  issue to the external multiplier
//   mul_p                multiplier product, MUL_LAT cycles after issue
module gf233_karatsuba_seq #(
  parameter int MUL_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [232:0] a,
  input  logic [232:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [464:0] d,
  output logic         mul_valid,
  output logic [116:0] mul_a,
  output logic [116:0] mul_b,
  input  logic [233:0] mul_p
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE0,
    ISSUE2,
    ISSUE1,
    DRAIN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_Z0,
    TAG_Z2,
    TAG_Z1
  } tag_t;

  state_t       r_state;
  tag_t         r_tag [MUL_LAT];
  logic [232:0] r_a;
  logic [232:0] r_b;
  logic [233:0] r_z0;
  logic [233:0] r_z1;
  logic [233:0] r_z2;
  logic         r_z1_ok;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_mul_valid;
  logic [116:0] r_mul_a;
  logic [116:0] r_mul_b;
  logic [464:0] r_d;

  tag_t         w_tag_in;
  tag_t         w_tag_out;
  logic [116:0] w_a_mid;
  logic [116:0] w_b_mid;
  logic [233:0] w_mid;
  logic [464:0] w_d;

  assign w_a_mid = {1'b0, r_a[115:0]} ^ r_a[232:116];
  assign w_b_mid = {1'b0, r_b[115:0]} ^ r_b[232:116];

  // z1 ^ z2 ^ z0 leaves only the cross terms a_lo*b_hi ^ a_hi*b_lo
  assign w_mid = r_z1 ^ r_z2 ^ r_z0;

  assign w_d = ({231'b0, r_z2} << 232)
             ^ ({231'b0, w_mid} << 116)
             ^ {231'b0, r_z0};

  assign w_tag_out = r_tag[MUL_LAT-1];

  // Tag of the issue presented this cycle; it rides the shift
  // register so it reaches the end exactly when mul_p is valid.
  always_comb begin
    w_tag_in = TAG_NONE;
    unique case (1'b1)
      (r_state == ISSUE0): w_tag_in = TAG_Z0;
      (r_state == ISSUE2): w_tag_in = TAG_Z2;
      (r_state == ISSUE1): w_tag_in = TAG_Z1;
      default:             w_tag_in = TAG_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      for (int i = 0; i < MUL_LAT; i++)
        r_tag[i] <= TAG_NONE;
      r_a         <= '0;
      r_b         <= '0;
      r_z0        <= '0;
      r_z1        <= '0;
      r_z2        <= '0;
      r_z1_ok     <= 1'b0;
      r_d         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_mul_valid <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < MUL_LAT; i++)
        r_tag[i] <= r_tag[i-1];

      unique case (1'b1)
        (w_tag_out == TAG_Z0): r_z0 <= mul_p;
        (w_tag_out == TAG_Z2): r_z2 <= mul_p;
        (w_tag_out == TAG_Z1): begin
          r_z1    <= mul_p;
          r_z1_ok <= 1'b1;
        end
        default: ;
      endcase

      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a         <= a;
            r_b         <= b;
            r_mul_valid <= 1'b1;
            r_mul_a     <= {1'b0, a[115:0]};
            r_mul_b     <= {1'b0, b[115:0]};
            r_in_ready  <= 1'b0;
            r_state     <= ISSUE0;
          end
        end
        ISSUE0: begin
          r_mul_a <= r_a[232:116];
          r_mul_b <= r_b[232:116];
          r_state <= ISSUE2;
        end
        ISSUE2: begin
          r_mul_a <= w_a_mid;
          r_mul_b <= w_b_mid;
          r_state <= ISSUE1;
        end
        ISSUE1: begin
          r_mul_valid <= 1'b0;
          r_mul_a     <= '0;
          r_mul_b     <= '0;
          r_state     <= DRAIN;
        end
        DRAIN: begin
          if (r_z1_ok) begin
            r_d         <= w_d;
            r_out_valid <= 1'b1;
            r_z1_ok     <= 1'b0;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign d         = r_d;
  assign mul_valid = r_mul_valid;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;

endmodule
